// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue between dispatch and the memory FU.
// Tracks operand readiness via wakeup broadcasts; issues only the head; squashes wrong-path tail on mispredict.
module mem_issue_queue #(
  parameter int DEPTH  = 8,
  parameter int PTAG_W = 7,
  parameter int ROB_W  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       disp_valid,
  input  logic [6:0]                 disp_opcode,
  input  logic [31:0]                disp_imm,
  input  logic [PTAG_W-1:0]          disp_ps1,
  input  logic                       disp_ps1_rdy,
  input  logic [PTAG_W-1:0]          disp_ps2,
  input  logic                       disp_ps2_rdy,
  input  logic [PTAG_W-1:0]          disp_pd,
  input  logic [ROB_W-1:0]           disp_rob,
  output logic                       full,
  input  logic                       wb0_valid,
  input  logic [PTAG_W-1:0]          wb0_tag,
  input  logic                       wb1_valid,
  input  logic [PTAG_W-1:0]          wb1_tag,
  input  logic                       fu_ready,
  output logic                       iss_valid,
  output logic [6:0]                 iss_opcode,
  output logic [31:0]                iss_imm,
  output logic [PTAG_W-1:0]          iss_ps1,
  output logic [PTAG_W-1:0]          iss_ps2,
  output logic [PTAG_W-1:0]          iss_pd,
  output logic [ROB_W-1:0]           iss_rob,
  input  logic [ROB_W-1:0]           rob_head,
  input  logic                       mispredict,
  input  logic [ROB_W-1:0]           mispredict_tag,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [31:0]       imm;
    logic [PTAG_W-1:0] ps1;
    logic [PTAG_W-1:0] ps2;
    logic [PTAG_W-1:0] pd;
    logic [ROB_W-1:0]  rob;
    logic              rdy1;
    logic              rdy2;
  } entry_t;

  entry_t             ent_q [DEPTH];
  entry_t             ent_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d, nsq;
  entry_t             head_e;
  logic               nonempty, push, pop;
  logic [ROB_W-1:0]   mp_age, ent_age;
  logic [PTR_W-1:0]   offs;

  function automatic logic hit(input logic [PTAG_W-1:0] t,
                               input logic v0, input logic [PTAG_W-1:0] t0,
                               input logic v1, input logic [PTAG_W-1:0] t1);
    return (v0 && (t0 == t)) || (v1 && (t1 == t));
  endfunction

  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign head_e   = ent_q[head_q];
  assign nonempty = (count_q != '0);

  // Issue reads only stored rdy bits, so a same-cycle wakeup issues next cycle.
  assign iss_valid  = nonempty && head_e.rdy1 && head_e.rdy2 && fu_ready && !mispredict && !reset;
  assign iss_opcode = nonempty ? head_e.opcode : '0;
  assign iss_imm    = nonempty ? head_e.imm    : '0;
  assign iss_ps1    = nonempty ? head_e.ps1    : '0;
  assign iss_ps2    = nonempty ? head_e.ps2    : '0;
  assign iss_pd     = nonempty ? head_e.pd     : '0;
  assign iss_rob    = nonempty ? head_e.rob    : '0;

  assign push   = disp_valid && !full && !mispredict;
  assign pop    = iss_valid;
  assign mp_age = mispredict_tag - rob_head;

  always_comb begin
    ent_d   = ent_q;
    nsq     = '0;
    offs    = '0;
    ent_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs    = PTR_W'(i) - head_q;
      ent_age = ent_q[i].rob - rob_head;
      if ({1'b0, offs} < count_q) begin
        ent_d[i].rdy1 = ent_q[i].rdy1 | hit(ent_q[i].ps1, wb0_valid, wb0_tag, wb1_valid, wb1_tag);
        ent_d[i].rdy2 = ent_q[i].rdy2 | hit(ent_q[i].ps2, wb0_valid, wb0_tag, wb1_valid, wb1_tag);
        if (ent_age > mp_age) nsq = nsq + CNT_W'(1);
      end
    end
    if (push) begin
      ent_d[tail_q].opcode = disp_opcode;
      ent_d[tail_q].imm    = disp_imm;
      ent_d[tail_q].ps1    = disp_ps1;
      ent_d[tail_q].ps2    = disp_ps2;
      ent_d[tail_q].pd     = disp_pd;
      ent_d[tail_q].rob    = disp_rob;
      ent_d[tail_q].rdy1   = disp_ps1_rdy | hit(disp_ps1, wb0_valid, wb0_tag, wb1_valid, wb1_tag);
      ent_d[tail_q].rdy2   = (disp_opcode == OP_LOAD) | disp_ps2_rdy
                             | hit(disp_ps2, wb0_valid, wb0_tag, wb1_valid, wb1_tag);
    end
    head_d = head_q + PTR_W'(pop);
    // Wrong-path ops are always the youngest, so the squash just pulls the tail back.
    if (mispredict) begin
      tail_d  = tail_q - PTR_W'(nsq);
      count_d = count_q - nsq;
    end else begin
      tail_d  = tail_q + PTR_W'(push);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
  end
endmodule

// File: tb/tb_mem_issue_queue.sv
// Random + directed bench for mem_issue_queue against a queue-based reference model.
module tb_mem_issue_queue;
  logic        clk = 0;
  logic        reset, disp_valid, disp_ps1_rdy, disp_ps2_rdy;
  logic [6:0]  disp_opcode, disp_ps1, disp_ps2, disp_pd;
  logic [31:0] disp_imm;
  logic [4:0]  disp_rob, rob_head, mispredict_tag;
  logic        wb0_valid, wb1_valid, fu_ready, mispredict;
  logic [6:0]  wb0_tag, wb1_tag;
  logic        full, iss_valid;
  logic [6:0]  iss_opcode, iss_ps1, iss_ps2, iss_pd;
  logic [31:0] iss_imm;
  logic [4:0]  iss_rob;
  logic [3:0]  count;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011;

  mem_issue_queue dut (
    .clk(clk), .reset(reset), .disp_valid(disp_valid), .disp_opcode(disp_opcode),
    .disp_imm(disp_imm), .disp_ps1(disp_ps1), .disp_ps1_rdy(disp_ps1_rdy),
    .disp_ps2(disp_ps2), .disp_ps2_rdy(disp_ps2_rdy), .disp_pd(disp_pd),
    .disp_rob(disp_rob), .full(full), .wb0_valid(wb0_valid), .wb0_tag(wb0_tag),
    .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .fu_ready(fu_ready),
    .iss_valid(iss_valid), .iss_opcode(iss_opcode), .iss_imm(iss_imm),
    .iss_ps1(iss_ps1), .iss_ps2(iss_ps2), .iss_pd(iss_pd), .iss_rob(iss_rob),
    .rob_head(rob_head), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op; logic [31:0] imm; logic [6:0] ps1, ps2, pd; logic [4:0] rob;
    bit r1, r2;
  } m_t;
  m_t q[$];

  int n_chk = 0, n_pass = 0;

  function automatic void chk(string tag, logic [95:0] got, logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endfunction

  function automatic bit hit(logic [6:0] t);
    return (wb0_valid && wb0_tag == t) || (wb1_valid && wb1_tag == t);
  endfunction

  function automatic logic [4:0] age(logic [4:0] x);
    return x - rob_head;
  endfunction

  task automatic idle();
    reset = 0; disp_valid = 0; disp_opcode = LD; disp_imm = 0; disp_ps1 = 0;
    disp_ps1_rdy = 0; disp_ps2 = 0; disp_ps2_rdy = 0; disp_pd = 0; disp_rob = 0;
    wb0_valid = 0; wb0_tag = 0; wb1_valid = 0; wb1_tag = 0;
    mispredict = 0; mispredict_tag = 0;
  endtask

  task automatic disp(logic [6:0] op, logic [6:0] p1, bit r1, logic [6:0] p2, bit r2,
                      logic [6:0] pd, logic [4:0] rob);
    disp_valid = 1; disp_opcode = op; disp_ps1 = p1; disp_ps1_rdy = r1;
    disp_ps2 = p2; disp_ps2_rdy = r2; disp_pd = pd; disp_rob = rob;
    disp_imm = $urandom;
  endtask

  // Check outputs against the model, then advance model and DUT by one clock.
  task automatic step();
    bit ev; int sz0; m_t n; logic [64:0] ef;
    #1;
    sz0 = q.size();
    ev = !reset && sz0 != 0 && q[0].r1 && q[0].r2 && fu_ready && !mispredict;
    ef = (sz0 != 0) ? {q[0].op, q[0].imm, q[0].ps1, q[0].ps2, q[0].pd, q[0].rob} : '0;
    chk("iss_valid", 96'(iss_valid), 96'(ev));
    chk("count", 96'(count), 96'(sz0));
    chk("full", 96'(full), 96'(sz0 == 8));
    chk("iss_fields", 96'({iss_opcode, iss_imm, iss_ps1, iss_ps2, iss_pd, iss_rob}), 96'(ef));
    if (!reset && disp_valid && sz0 == 8 && !mispredict)
      $display("note: protocol error, dispatch while full dropped");
    if (reset) q.delete();
    else begin
      if (mispredict) begin
        for (int i = sz0 - 1; i >= 0; i--)
          if (age(q[i].rob) > age(mispredict_tag)) q.delete(i);
      end else if (ev) q.pop_front();
      foreach (q[i]) begin
        q[i].r1 = q[i].r1 | hit(q[i].ps1);
        q[i].r2 = q[i].r2 | hit(q[i].ps2);
      end
      if (!mispredict && disp_valid && sz0 < 8) begin
        n.op = disp_opcode; n.imm = disp_imm; n.ps1 = disp_ps1; n.ps2 = disp_ps2;
        n.pd = disp_pd; n.rob = disp_rob;
        n.r1 = disp_ps1_rdy | hit(disp_ps1);
        n.r2 = (disp_opcode == LD) | disp_ps2_rdy | hit(disp_ps2);
        q.push_back(n);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(); reset = 1; step(); step(); reset = 0;
  endtask

  logic [4:0] next_rob;
  bit acc;

  initial begin
    idle(); fu_ready = 0; rob_head = 0;
    @(negedge clk);
    reset = 1; step(); step(); reset = 0;
    #1;
    chk("rst_count", 96'(count), 0);
    chk("rst_full", 96'(full), 0);
    chk("rst_iss", 96'(iss_valid), 0);

    // single ready load issues the cycle after dispatch
    fu_ready = 1;
    disp(LD, 7'd10, 1, 7'd0, 0, 7'd33, 5'd3); step(); idle();
    #1; chk("t1_iss", 96'(iss_valid), 1); chk("t1_rob", 96'(iss_rob), 3);
    chk("t1_pd", 96'(iss_pd), 33); chk("t1_cnt1", 96'(count), 1);
    step(); #1; chk("t1_cnt0", 96'(count), 0);

    // store waits for ps2 wakeup; issues the cycle after the broadcast
    disp(ST, 7'd12, 1, 7'd20, 0, 7'd0, 5'd4); step(); idle();
    repeat (3) begin #1; chk("t2_wait", 96'(iss_valid), 0); step(); end
    wb0_valid = 1; wb0_tag = 7'd20; #1; chk("t2_wbcyc", 96'(iss_valid), 0); step(); idle();
    #1; chk("t2_iss", 96'(iss_valid), 1); step();

    // blocked head holds back a ready younger op
    disp(LD, 7'd40, 0, 7'd0, 0, 7'd1, 5'd5); step();
    disp(LD, 7'd41, 1, 7'd0, 0, 7'd2, 5'd6); step(); idle();
    repeat (2) begin #1; chk("t3_block", 96'(iss_valid), 0); step(); end
    wb1_valid = 1; wb1_tag = 7'd40; step(); idle();
    #1; chk("t3_first", 96'(iss_rob), 5); step();
    #1; chk("t3_second", 96'(iss_rob), 6); step();

    // fill, then dispatch-while-full alongside an issue
    fu_ready = 0;
    for (int i = 0; i < 8; i++) begin disp(LD, 7'd1, 1, 7'd0, 0, 7'(i), 5'(i)); step(); end
    idle(); #1; chk("t4_full", 96'(full), 1); chk("t4_cnt", 96'(count), 8);
    fu_ready = 1; disp(LD, 7'd1, 1, 7'd0, 0, 7'd99, 5'd9); step(); idle(); fu_ready = 0;
    #1; chk("t4_cnt7", 96'(count), 7); chk("t4_nfull", 96'(full), 0);

    // mispredict squashes younger-than-tag suffix
    do_reset(); rob_head = 1;
    disp(LD, 7'd1, 1, 7'd0, 0, 7'd0, 5'd2); step();
    disp(ST, 7'd1, 1, 7'd2, 1, 7'd0, 5'd4); step();
    disp(LD, 7'd1, 1, 7'd0, 0, 7'd0, 5'd6); step();
    disp(LD, 7'd1, 1, 7'd0, 0, 7'd0, 5'd9); step(); idle();
    mispredict = 1; mispredict_tag = 5'd4; step(); idle();
    #1; chk("t5_cnt", 96'(count), 2);
    fu_ready = 1; #1; chk("t5_r2", 96'(iss_rob), 2); step();
    #1; chk("t5_r4", 96'(iss_rob), 4); step();

    // steady-state wrap-around
    rob_head = 0;
    for (int i = 0; i < 20; i++) begin
      disp(LD, 7'd3, 1, 7'd0, 0, 7'(i), 5'(i)); #1;
      chk("t6_cnt", 96'(count <= 1), 1); step();
    end
    idle(); step(); step();

    // randomized traffic
    do_reset(); next_rob = 0;
    for (int c = 0; c < 1500; c++) begin
      idle();
      fu_ready = ($urandom_range(0, 3) != 0);
      rob_head = (q.size() != 0 ? q[0].rob : next_rob) - 5'($urandom_range(0, 2));
      if ($urandom_range(0, 2) != 0)
        disp($urandom_range(0, 1) ? LD : ST, 7'($urandom_range(0, 15)), $urandom_range(0, 1),
             7'($urandom_range(0, 15)), $urandom_range(0, 1), 7'($urandom), next_rob);
      wb0_valid = ($urandom_range(0, 4) < 2); wb0_tag = 7'($urandom_range(0, 15));
      wb1_valid = ($urandom_range(0, 4) < 2); wb1_tag = 7'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) begin
        mispredict = 1;
        mispredict_tag = q.size() != 0 ? q[$urandom_range(0, q.size() - 1)].rob : rob_head;
      end
      if (c == 700) reset = 1;
      acc = disp_valid && !reset && !mispredict && q.size() < 8;
      step();
      if (acc) next_rob = next_rob + 5'd1;
      else if (mispredict && !reset) next_rob = mispredict_tag + 5'd1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
